// File: rtl/uart_rx_shift.sv
// UART receive datapath: collects start, d0..d7, parity on control-FSM enable pulses, then samples stop and commits; UART_RX_PARITY_CHECK_EN enables parity checking.
// Commit lands on the 2nd edge after the parity sample; no backpressure, an unread byte is overwritten and flagged by sticky overrun.
module uart_rx_shift #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_2br,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  input  logic       rd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, STOP_WAIT, STOP_SAMPLE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shift_reg;
  logic       start_bit;
`ifdef UART_RX_PARITY_CHECK_EN
  logic       parity_bit;
`else
  logic       unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

  always_ff @(posedge clk_2br or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      shift_reg  <= 8'h00;
      start_bit  <= 1'b0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            start_bit <= rx;
            cnt       <= 4'd1;
            state     <= COLLECT;
            busy      <= 1'b1;
          end
        end
        COLLECT: begin
          if (enable) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd9) begin
`ifdef UART_RX_PARITY_CHECK_EN
              parity_bit <= rx;
`endif
              state <= STOP_WAIT;
            end else begin
              // LSB arrives first, so shifting right leaves d0 in bit 0
              shift_reg <= {rx, shift_reg[7:1]};
            end
          end
        end
        STOP_WAIT: state <= STOP_SAMPLE;
        STOP_SAMPLE: begin
          state <= IDLE;
          cnt   <= 4'd0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A commit beats a simultaneous read: the new byte stays valid and overrun is not raised
      if (state == STOP_SAMPLE) begin
        data       <= shift_reg;
        frame_err  <= start_bit | ~rx;
        data_valid <= 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
        parity_err <= (^{shift_reg, parity_bit}) != PARITY_ODD;
`endif
        if (data_valid && !rd)
          overrun <= 1'b1;
        else if (data_valid && rd)
          overrun <= 1'b0;
      end else if (rd && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_shift.sv
// Bench for uart_rx_shift: directed frames plus random frames against a frame-level reference model.
module tb_uart_rx_shift;

  localparam bit P_ODD = 1'b0;

  logic       clk_2br = 1'b0;
  logic       reset   = 1'b0;
  logic       rx      = 1'b1;
  logic       enable  = 1'b0;
  logic       rd      = 1'b0;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, overrun, busy;

  uart_rx_shift #(.PARITY_ODD(P_ODD)) dut (
    .clk_2br    (clk_2br),
    .reset      (reset),
    .rx         (rx),
    .enable     (enable),
    .rd         (rd),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk_2br = ~clk_2br;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_data  = 8'h00;
  bit         exp_valid = 1'b0;
  bit         exp_perr  = 1'b0;
  bit         exp_ferr  = 1'b0;
  bit         exp_ovr   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"},  data,                exp_data);
    chk({tag, "_valid"}, 8'(data_valid),      8'(exp_valid));
    chk({tag, "_perr"},  8'(parity_err),      8'(exp_perr));
    chk({tag, "_ferr"},  8'(frame_err),       8'(exp_ferr));
    chk({tag, "_ovr"},   8'(overrun),         8'(exp_ovr));
    chk({tag, "_busy"},  8'(busy),            8'h00);
  endtask

  task automatic tick();
    @(posedge clk_2br);
    #1;
  endtask

  function automatic bit good_parity(input logic [7:0] b);
    return bit'(($countones(b) % 2) != 0) ^ P_ODD;
  endfunction

  // Sends one full frame as the control FSM would, then checks the committed result.
  task automatic send_frame(input logic [7:0] b, input bit start, input bit par,
                            input bit stop, input bit rd_c);
    logic [9:0] bits;
    bits = {par, b, start};
    for (int i = 0; i < 10; i++) begin
      rx     = bits[i];
      enable = 1'b1;
      tick();
      enable = 1'b0;
      if (i == 0) chk("busy_collect", 8'(busy), 8'h01);
      if (i < 9) begin
        repeat ($urandom_range(0, 2)) begin
          rx = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end
    rx     = stop;
    enable = 1'($urandom_range(0, 1));
    tick();
    chk("lat_valid", 8'(data_valid), 8'(exp_valid));
    chk("lat_busy",  8'(busy),       8'h01);
    rd     = rd_c;
    enable = 1'($urandom_range(0, 1));
    tick();
    rd     = 1'b0;
    enable = 1'b0;
    rx     = 1'b1;
    if (exp_valid && !rd_c) exp_ovr = 1'b1;
    else if (exp_valid && rd_c) exp_ovr = 1'b0;
    exp_data  = b;
    exp_valid = 1'b1;
    exp_ferr  = start || !stop;
`ifdef UART_RX_PARITY_CHECK_EN
    exp_perr  = (bit'(($countones(b) % 2) != 0) ^ par) != P_ODD;
`else
    exp_perr  = 1'b0;
`endif
    check_all("commit");
  endtask

  task automatic do_read();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
    check_all("read");
  endtask

  initial begin
    #12;
    check_all("reset");
    @(posedge clk_2br);
    #1 reset = 1'b1;
    tick();

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();
    send_frame(8'h3C, 1'b0, good_parity(8'h3C), 1'b0, 1'b0);
    do_read();
    send_frame(8'h3C, 1'b1, good_parity(8'h3C), 1'b1, 1'b0);
    do_read();
    do_read();

    send_frame(8'h11, 1'b0, good_parity(8'h11), 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, good_parity(8'h22), 1'b1, 1'b0);
    do_read();

    send_frame(8'h44, 1'b0, good_parity(8'h44), 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, good_parity(8'h55), 1'b1, 1'b1);
    do_read();

    // Abort a frame after its 5th pulse with an asynchronous reset
    for (int i = 0; i < 5; i++) begin
      rx     = 1'($urandom_range(0, 1));
      enable = 1'b1;
      tick();
      enable = 1'b0;
    end
    reset = 1'b0;
    #2;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    check_all("arst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_frame(8'h7E, 1'b0, good_parity(8'h7E), 1'b1, 1'b0);
    do_read();

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit start, par, stop, rd_c;
      b     = 8'($urandom);
      start = ($urandom_range(0, 7) == 0);
      par   = ($urandom_range(0, 3) == 0) ? ~good_parity(b) : good_parity(b);
      stop  = ($urandom_range(0, 7) != 0);
      rd_c  = ($urandom_range(0, 3) == 0);
      send_frame(b, start, par, stop, rd_c);
      if ($urandom_range(0, 2) == 0) do_read();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
